decode: RTL and testbench

- Decode stage sitting between fetch and the execute stage.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake.
- Extracts opecode/immf/cc fields, sign- or zero-extends the immediate, and reads operands from the internal 16x32 register file, which is written by writeback.
- Interlocks read-after-write hazards with a per-register busy scoreboard and issues a registered operand bundle to execute, with a nop bubble when stalled.

---
 rtl/decode_pkg.sv | 54 +++++
 rtl/decode_if.sv | 35 +++
 rtl/decode_regfile.sv | 35 +++
 rtl/decode.sv | 138 +++++++++++++
 tb/tb_decode.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared widths, instruction field positions, opecodes and class decoding for the decode stage.
package decode_pkg;

    localparam int LEN_INSN    = 32;
    localparam int LEN_OPECODE = 7;
    localparam int LEN_IMMF    = 1;
    localparam int LEN_REGNO   = 4;
    localparam int LEN_REG     = 32;
    localparam int LEN_CC      = 4;
    localparam int LEN_IMM_EX  = 32;
    localparam int NUM_REGS    = 1 << LEN_REGNO;

    localparam int POS_OPECODE = 25;
    localparam int POS_IMMF    = 24;
    localparam int POS_RD      = 20;
    localparam int POS_RS      = 16;
    localparam int POS_CC      = 12;

    localparam logic [LEN_OPECODE-1:0] OP_NOP = 7'b111_1110;
    localparam logic [LEN_OPECODE-1:0] OP_HLT = 7'b111_1111;
    localparam logic [LEN_OPECODE-1:0] OP_LD  = 7'b001_1000;
    localparam logic [LEN_OPECODE-1:0] OP_ST  = 7'b001_1001;
    localparam logic [LEN_OPECODE-1:0] OP_J   = 7'b001_1010;
    localparam logic [LEN_OPECODE-1:0] OP_JA  = 7'b001_1011;
    localparam logic [LEN_OPECODE-1:0] OP_CMP = 7'b000_0100;

    localparam logic [LEN_OPECODE-1:0] MASK_ALU    = 7'b111_0000;
    localparam logic [LEN_OPECODE-1:0] CLASS_ALU   = 7'b000_0000;
    localparam logic [LEN_OPECODE-1:0] MASK_LOGIC  = 7'b111_1000;
    localparam logic [LEN_OPECODE-1:0] CLASS_LOGIC = 7'b001_0000;

    typedef enum logic {RUN, HALT} state_e;

    function automatic logic is_alu(input logic [LEN_OPECODE-1:0] op);
        return (op & MASK_ALU) == CLASS_ALU;
    endfunction

    function automatic logic is_logic(input logic [LEN_OPECODE-1:0] op);
        return (op & MASK_LOGIC) == CLASS_LOGIC;
    endfunction

    function automatic logic writes_rd(input logic [LEN_OPECODE-1:0] op);
        return (is_alu(op) && op != OP_CMP) || is_logic(op) || op == OP_LD;
    endfunction

    function automatic logic reads_rd(input logic [LEN_OPECODE-1:0] op);
        return is_alu(op) || is_logic(op) || op == OP_ST;
    endfunction

    function automatic logic reads_rs(input logic [LEN_OPECODE-1:0] op, input logic immf);
        return !immf && op != OP_NOP && op != OP_HLT;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch, writeback and execute-side signals of the decode stage.
interface decode_if;
    import decode_pkg::*;

    logic [LEN_INSN-1:0]    insn_i;
    logic                   insn_valid;
    logic                   insn_ready;
    logic                   flush;
    logic                   wb_en;
    logic [LEN_REGNO-1:0]   wb_regno;
    logic [LEN_REG-1:0]     wb_data;
    logic                   ex_valid;
    logic [LEN_OPECODE-1:0] opecode;
    logic [LEN_IMMF-1:0]    immf;
    logic [LEN_REG-1:0]     data_rd;
    logic [LEN_REG-1:0]     data_rs;
    logic [LEN_CC-1:0]      cc;
    logic [LEN_IMM_EX-1:0]  imm_ex;
    logic [LEN_REGNO-1:0]   dst_regno;
    logic                   dst_we;
    logic                   halted;

    modport master (
        output insn_i, insn_valid, flush, wb_en, wb_regno, wb_data,
        input  insn_ready, ex_valid, opecode, immf, data_rd, data_rs, cc, imm_ex,
               dst_regno, dst_we, halted
    );

    modport slave (
        input  insn_i, insn_valid, flush, wb_en, wb_regno, wb_data,
        output insn_ready, ex_valid, opecode, immf, data_rd, data_rs, cc, imm_ex,
               dst_regno, dst_we, halted
    );

endinterface

// File: rtl/decode_regfile.sv
// 16x32 register file, two read ports and one write port.
// DECODE_BYPASS_EN forwards a same-cycle write to the read ports.
module decode_regfile
    import decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [LEN_REGNO-1:0] wr_addr,
    input  logic [LEN_REG-1:0]   wr_data,
    input  logic [LEN_REGNO-1:0] rd_addr,
    input  logic [LEN_REGNO-1:0] rs_addr,
    output logic [LEN_REG-1:0]   rd_data,
    output logic [LEN_REG-1:0]   rs_data
);

    logic [LEN_REG-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rd_data = (we && wr_addr == rd_addr) ? wr_data : regs[rd_addr];
    assign rs_data = (we && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
`else
    assign rd_data = regs[rd_addr];
    assign rs_data = regs[rs_addr];
`endif

endmodule

// File: rtl/decode.sv
// Decode stage: one-entry holding slot, busy scoreboard for RAW interlock, registered issue bundle.
// DECODE_BYPASS_EN lets a busy bit cleared by this cycle's writeback release the dependent instruction.
module decode
    import decode_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);

    state_e                 state, state_next;
    logic                   slot_valid;
    logic [LEN_INSN-1:0]    slot_insn;
    logic [NUM_REGS-1:0]    busy, busy_live, wb_mask, set_mask;

    logic [LEN_OPECODE-1:0] op;
    logic                   immf;
    logic [LEN_REGNO-1:0]   rd, rs;
    logic [LEN_CC-1:0]      cc;
    logic [15:0]            imm16;
    logic [LEN_IMM_EX-1:0]  imm_ext;
    logic [LEN_REG-1:0]     rd_val, rs_val;
    logic                   halted, hazard, issue, ready, accept;

    logic                   ex_valid_r, immf_r, dst_we_r;
    logic [LEN_OPECODE-1:0] opecode_r;
    logic [LEN_REG-1:0]     data_rd_r, data_rs_r;
    logic [LEN_CC-1:0]      cc_r;
    logic [LEN_IMM_EX-1:0]  imm_ex_r;
    logic [LEN_REGNO-1:0]   dst_regno_r;

    assign op    = slot_insn[POS_OPECODE +: LEN_OPECODE];
    assign immf  = slot_insn[POS_IMMF];
    assign rd    = slot_insn[POS_RD +: LEN_REGNO];
    assign rs    = slot_insn[POS_RS +: LEN_REGNO];
    assign cc    = slot_insn[POS_CC +: LEN_CC];
    assign imm16 = slot_insn[15:0];

    assign imm_ext = is_logic(op) ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};

    decode_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_en),
        .wr_addr (bus.wb_regno),
        .wr_data (bus.wb_data),
        .rd_addr (rd),
        .rs_addr (rs),
        .rd_data (rd_val),
        .rs_data (rs_val)
    );

    assign wb_mask  = bus.wb_en ? (NUM_REGS'(1) << bus.wb_regno) : '0;
    assign set_mask = (issue && writes_rd(op)) ? (NUM_REGS'(1) << rd) : '0;

`ifdef DECODE_BYPASS_EN
    assign busy_live = busy & ~wb_mask;
`else
    assign busy_live = busy;
`endif

    assign halted = (state == HALT);
    assign hazard = (reads_rd(op) && busy_live[rd]) || (reads_rs(op, immf) && busy_live[rs]);
    assign issue  = slot_valid && !bus.flush && !halted && !hazard;
    assign ready  = !halted && !bus.flush && (!slot_valid || issue);
    assign accept = bus.insn_valid && ready;

    always_comb begin
        state_next = state;
        if (state == RUN && issue && op == OP_HLT) state_next = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_insn  <= '0;
        end else if (bus.flush && !halted) begin
            slot_valid <= 1'b0;
        end else if (accept) begin
            slot_valid <= 1'b1;
            slot_insn  <= bus.insn_i;
        end else if (issue) begin
            slot_valid <= 1'b0;
        end
    end

    // Setting from an issue is applied after the writeback clear, so set wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r  <= 1'b0;
            opecode_r   <= OP_NOP;
            immf_r      <= 1'b0;
            data_rd_r   <= '0;
            data_rs_r   <= '0;
            cc_r        <= '0;
            imm_ex_r    <= '0;
            dst_regno_r <= '0;
            dst_we_r    <= 1'b0;
        end else if (issue) begin
            ex_valid_r  <= 1'b1;
            opecode_r   <= op;
            immf_r      <= immf;
            data_rd_r   <= rd_val;
            data_rs_r   <= immf ? imm_ext : rs_val;
            cc_r        <= cc;
            imm_ex_r    <= imm_ext;
            dst_regno_r <= rd;
            dst_we_r    <= writes_rd(op);
        end else begin
            ex_valid_r  <= 1'b0;
            opecode_r   <= OP_NOP;
            dst_we_r    <= 1'b0;
        end
    end

    assign bus.insn_ready = ready;
    assign bus.halted     = halted;
    assign bus.ex_valid   = ex_valid_r;
    assign bus.opecode    = opecode_r;
    assign bus.immf       = immf_r;
    assign bus.data_rd    = data_rd_r;
    assign bus.data_rs    = data_rs_r;
    assign bus.cc         = cc_r;
    assign bus.imm_ex     = imm_ex_r;
    assign bus.dst_regno  = dst_regno_r;
    assign bus.dst_we     = dst_we_r;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: vector table plus hand sequences, issued bundles checked via a scoreboard queue.
module tb_decode;
    import decode_pkg::*;

`ifdef DECODE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  opecode;
        logic        immf;
        logic [31:0] data_rd;
        logic [31:0] data_rs;
        logic [3:0]  cc;
        logic [31:0] imm_ex;
        logic [3:0]  dst_regno;
        logic        dst_we;
    } bundle_t;

    typedef struct {
        logic [31:0] insn;
        bundle_t     exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    bundle_t exp_q[$];
    vec_t vecs[11];

    decode_if bus();

    decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic im, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [15:0] imm);
        return {op, im, rd, rs, imm};
    endfunction

    function automatic bundle_t b(input logic [6:0] op, input logic im, input logic [31:0] drd,
                                  input logic [31:0] drs, input logic [3:0] c, input logic [31:0] imm,
                                  input logic [3:0] dst, input logic we);
        bundle_t r;
        r.opecode = op; r.immf = im; r.data_rd = drd; r.data_rs = drs;
        r.cc = c; r.imm_ex = imm; r.dst_regno = dst; r.dst_we = we;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] insn, input bundle_t exp, input bit tracked);
        bus.insn_i     = insn;
        bus.insn_valid = 1'b1;
        #1;
        for (int i = 0; i < 200 && !bus.insn_ready; i++) cyc();
        check_output("accept_ready", bus.insn_ready, 1'b1);
        cyc();
        bus.insn_valid = 1'b0;
        if (tracked) exp_q.push_back(exp);
    endtask

    task automatic wb(input logic [3:0] regno, input logic [31:0] data);
        bus.wb_en    = 1'b1;
        bus.wb_regno = regno;
        bus.wb_data  = data;
        cyc();
        bus.wb_en    = 1'b0;
    endtask

    // Every issued bundle must match the oldest expected entry.
    always begin
        @(posedge clk);
        #2;
        if (bus.ex_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_issue", {bus.opecode, bus.dst_regno}, 11'd0);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                check_output("bundle",
                             {bus.opecode, bus.immf, bus.data_rd, bus.data_rs, bus.cc,
                              bus.imm_ex, bus.dst_regno, bus.dst_we}, e);
            end
        end
    end

    initial begin
        vecs[0]  = '{mk(7'h00,0,1,2,16'h0000),  b(7'h00,0,32'h1111_1111,32'h2222_2222,4'h0,32'h0000_0000,1,1)};
        vecs[1]  = '{mk(7'h10,1,3,4,16'h8001),  b(7'h10,1,32'h3333_3333,32'h0000_8001,4'h8,32'h0000_8001,3,1)};
        vecs[2]  = '{mk(7'h00,1,3,4,16'h8001),  b(7'h00,1,32'h3333_3333,32'hFFFF_8001,4'h8,32'hFFFF_8001,3,1)};
        vecs[3]  = '{mk(7'h04,0,5,6,16'h1234),  b(7'h04,0,32'h5555_5555,32'h6666_6666,4'h1,32'h0000_1234,5,0)};
        vecs[4]  = '{mk(7'h19,1,7,8,16'hFFFE),  b(7'h19,1,32'h7777_7777,32'hFFFF_FFFE,4'hF,32'hFFFF_FFFE,7,0)};
        vecs[5]  = '{mk(7'h18,0,9,10,16'h0000), b(7'h18,0,32'h9999_9999,32'hAAAA_AAAA,4'h0,32'h0000_0000,9,1)};
        vecs[6]  = '{mk(7'h1A,1,0,0,16'h7FFF),  b(7'h1A,1,32'h0000_0000,32'h0000_7FFF,4'h7,32'h0000_7FFF,0,0)};
        vecs[7]  = '{mk(7'h0A,0,11,12,16'h0000),b(7'h0A,0,32'hBBBB_BBBB,32'hCCCC_CCCC,4'h0,32'h0000_0000,11,1)};
        vecs[8]  = '{mk(7'h7E,0,13,14,16'h0000),b(7'h7E,0,32'hDDDD_DDDD,32'hEEEE_EEEE,4'h0,32'h0000_0000,13,0)};
        vecs[9]  = '{mk(7'h05,0,15,1,16'h0000), b(7'h05,0,32'hFFFF_FFFF,32'h1111_1111,4'h0,32'h0000_0000,15,1)};
        vecs[10] = '{mk(7'h17,1,2,0,16'hF00F),  b(7'h17,1,32'h2222_2222,32'h0000_F00F,4'hF,32'h0000_F00F,2,1)};

        bus.insn_i = '0; bus.insn_valid = 1'b0; bus.flush = 1'b0;
        bus.wb_en = 1'b0; bus.wb_regno = '0; bus.wb_data = '0;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check_output("reset_ex_valid", bus.ex_valid, 1'b0);
        check_output("reset_opecode", bus.opecode, 7'h7E);
        check_output("reset_ready", bus.insn_ready, 1'b1);
        check_output("reset_halted", bus.halted, 1'b0);
        check_output("reset_data_rs", bus.data_rs, 32'd0);
        check_output("reset_imm_ex", bus.imm_ex, 32'd0);
        check_output("reset_dst_we", bus.dst_we, 1'b0);

        // RAW interlock on r1; release timing depends on the bypass build.
        apply_stimulus(mk(7'h00,0,1,2,16'h0), b(7'h00,0,32'd0,32'd0,4'h0,32'd0,1,1), 1'b1);
        apply_stimulus(mk(7'h01,0,3,1,16'h0), b(7'h01,0,32'd0,32'h55,4'h0,32'd0,3,1), 1'b1);
        cyc();
        check_output("raw_stall_valid", bus.ex_valid, 1'b0);
        check_output("raw_stall_nop", bus.opecode, 7'h7E);
        bus.wb_en = 1'b1; bus.wb_regno = 4'd1; bus.wb_data = 32'h55;
        cyc();
        bus.wb_en = 1'b0;
        check_output("raw_release_edge", bus.ex_valid, BYPASS);
        cyc();
        check_output("raw_release_late", bus.ex_valid, !BYPASS);

        for (int n = 1; n < 16; n++) wb(4'(n), 32'(n) * 32'h1111_1111);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].insn, vecs[i].exp, 1'b1);
            cyc();
            if (vecs[i].exp.dst_we)
                wb(vecs[i].exp.dst_regno, 32'(vecs[i].exp.dst_regno) * 32'h1111_1111);
        end

        // Flush drops a stalled instruction but keeps busy[1].
        apply_stimulus(mk(7'h00,0,1,2,16'h0), b(7'h00,0,32'h1111_1111,32'h2222_2222,4'h0,32'd0,1,1), 1'b1);
        apply_stimulus(mk(7'h01,0,3,1,16'h0), '0, 1'b0);
        bus.flush = 1'b1;
        #1;
        check_output("flush_ready", bus.insn_ready, 1'b0);
        cyc();
        bus.flush = 1'b0;
        #1;
        check_output("flush_bubble", bus.ex_valid, 1'b0);
        check_output("flush_slot_empty", bus.insn_ready, 1'b1);
        apply_stimulus(mk(7'h00,0,6,1,16'h0), b(7'h00,0,32'h6666_6666,32'h1111_1111,4'h0,32'd0,6,1), 1'b1);
        cyc();
        check_output("flush_busy_kept", bus.ex_valid, 1'b0);
        wb(4'd1, 32'h1111_1111);
        cyc(); cyc();
        wb(4'd6, 32'h6666_6666);

        // Issue of ld r4 and writeback clear of r4 on the same edge: set wins.
        apply_stimulus(mk(7'h18,0,4,0,16'h0), b(7'h18,0,32'h4444_4444,32'd0,4'h0,32'd0,4,1), 1'b1);
        bus.wb_en = 1'b1; bus.wb_regno = 4'd4; bus.wb_data = 32'h4444_4444;
        apply_stimulus(mk(7'h00,0,5,4,16'h0), b(7'h00,0,32'h5555_5555,32'h4444_4444,4'h0,32'd0,5,1), 1'b1);
        bus.wb_en = 1'b0;
        cyc();
        check_output("set_wins_stall", bus.ex_valid, 1'b0);
        cyc();
        check_output("set_wins_stall2", bus.ex_valid, 1'b0);
        wb(4'd4, 32'h4444_4444);
        cyc(); cyc();
        wb(4'd5, 32'h5555_5555);

        apply_stimulus(mk(7'h7F,0,0,0,16'h0), b(7'h7F,0,32'd0,32'd0,4'h0,32'd0,0,0), 1'b1);
        cyc();
        check_output("hlt_valid", bus.ex_valid, 1'b1);
        check_output("hlt_opecode", bus.opecode, 7'h7F);
        check_output("hlt_halted", bus.halted, 1'b1);
        bus.insn_i = mk(7'h00,0,1,2,16'h0);
        bus.insn_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_output("halt_ready", bus.insn_ready, 1'b0);
            cyc();
            check_output("halt_bubble", bus.ex_valid, 1'b0);
        end
        bus.insn_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_output("rst_ready", bus.insn_ready, 1'b1);
        check_output("rst_halted", bus.halted, 1'b0);

        repeat (3) cyc();
        check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
